mu0_core: RTL and testbench

Parametrised MU0 processor core: the next generation of the team's MU0 simulator CPU, with configurable data/address width, an external request/acknowledge memory port tolerating wait states, explicit start/halt control and illegal-opcode trapping. It sits between the board-level control logic, which supplies `start`, and a shared single-port memory. An optional debug override path lets the host read and write memory while the core is stalled.

---
 rtl/mu0_pkg.sv | 27 ++
 rtl/mu0_alu.sv | 23 ++
 rtl/mu0_core.sv | 169 ++++++++++++++++
 tb/tb_mu0_core.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// MU0 shared definitions: opcodes, FSM states, ALU op encodings.
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_INC  = 2'd3;

  function automatic logic is_mem_op(input logic [3:0] op);
    return op <= OP_SUB;
  endfunction

endpackage

// File: rtl/mu0_alu.sv
// MU0 combinational ALU: pass-B, add, subtract, increment-A.
module mu0_alu
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = b;
    unique case (op)
      ALU_PASS: y = b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_INC:  y = a + DATA_W'(1);
    endcase
  end

endmodule

// File: rtl/mu0_core.sv
// MU0 core: FETCH/EXEC FSM with req/ack memory port and halt/trap.
// Define MU0_OVERRIDE_EN to add the host memory override path.
module mu0_core
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              memReq,
  output logic              memRnW,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
`ifdef MU0_OVERRIDE_EN
  input  logic              overrideEn,
  input  logic              overrideRnW,
  input  logic [ADDR_W-1:0] overrideAddr,
  input  logic [DATA_W-1:0] overrideWData,
  output logic [DATA_W-1:0] overrideRData,
`endif
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc
);

  logic [1:0]        state;
  logic              start_q;
  logic              start_edge;
  logic              frz;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              core_req;
  logic              core_rnw;
  logic [ADDR_W-1:0] core_addr;
  logic              ack;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_y;
  logic [ADDR_W-1:0] pc_inc;

  assign opcode     = ir[DATA_W-1 -: 4];
  assign operand    = ir[ADDR_W-1:0];
  assign start_edge = start & ~start_q;
  assign ack        = memAck & core_req & ~frz;

  always_comb begin
    core_req  = 1'b0;
    core_rnw  = 1'b1;
    core_addr = pc;
    unique case (1'b1)
      state == S_FETCH: core_req = 1'b1;
      state == S_EXEC && is_mem_op(opcode): begin
        core_req  = 1'b1;
        core_rnw  = opcode != OP_STO;
        core_addr = operand;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_op = ALU_PASS;
    unique case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      default: alu_op = ALU_PASS;
    endcase
  end

  mu0_alu #(.DATA_W(DATA_W)) u_alu (
    .op(alu_op),
    .a (acc),
    .b (memRData),
    .y (alu_y)
  );

  mu0_alu #(.DATA_W(ADDR_W)) u_pc_inc (
    .op(ALU_INC),
    .a (pc),
    .b (pc),
    .y (pc_inc)
  );

`ifdef MU0_OVERRIDE_EN
  // The host owns the port while overrideEn is high; the core stalls.
  assign frz           = overrideEn;
  assign memReq        = overrideEn | core_req;
  assign memRnW        = overrideEn ? overrideRnW : core_rnw;
  assign memAddr       = overrideEn ? overrideAddr : core_addr;
  assign memWData      = overrideEn ? overrideWData : acc;
  assign overrideRData = memRData;
`else
  assign frz      = 1'b0;
  assign memReq   = core_req;
  assign memRnW   = core_rnw;
  assign memAddr  = core_addr;
  assign memWData = acc;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      acc     <= '0;
      pc      <= '0;
      ir      <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else if (!frz) begin
      start_q <= start;
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start_edge) begin
            acc   <= '0;
            pc    <= '0;
            done  <= 1'b0;
            error <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (ack) begin
            ir    <= memRData;
            pc    <= pc_inc;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              if (ack) begin
                acc   <= alu_y;
                state <= S_FETCH;
              end
            end
            OP_STO: if (ack) state <= S_FETCH;
            OP_JMP: begin
              pc    <= operand;
              state <= S_FETCH;
            end
            OP_JGE: begin
              if (!acc[DATA_W-1]) pc <= operand;
              state <= S_FETCH;
            end
            OP_JNE: begin
              if (acc != '0) pc <= operand;
              state <= S_FETCH;
            end
            OP_STP: begin
              done  <= 1'b1;
              state <= S_HALT;
            end
            default: begin
              done  <= 1'b1;
              error <= 1'b1;
              state <= S_HALT;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_core.sv
// Directed bench for mu0_core: program table plus hand-written
// sequences for wrap, restart, mid-access reset and override.
module tb_mu0_core;

  logic        clk;
  logic        reset;
  logic        start;
  logic        memReq;
  logic        memRnW;
  logic [11:0] memAddr;
  logic [15:0] memWData;
  logic [15:0] memRData;
  logic        memAck;
  logic        done;
  logic        error;
  logic [15:0] ir;
  logic [11:0] pc;
  logic [15:0] acc;
`ifdef MU0_OVERRIDE_EN
  logic        overrideEn;
  logic        overrideRnW;
  logic [11:0] overrideAddr;
  logic [15:0] overrideWData;
  logic [15:0] overrideRData;
`endif

  mu0_core #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .memReq  (memReq),
    .memRnW  (memRnW),
    .memAddr (memAddr),
    .memWData(memWData),
    .memRData(memRData),
    .memAck  (memAck),
`ifdef MU0_OVERRIDE_EN
    .overrideEn   (overrideEn),
    .overrideRnW  (overrideRnW),
    .overrideAddr (overrideAddr),
    .overrideWData(overrideWData),
    .overrideRData(overrideRData),
`endif
    .done    (done),
    .error   (error),
    .ir      (ir),
    .pc      (pc),
    .acc     (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after wait_n wait cycles; loader port for setup.
  logic [15:0] mem [4096];
  int          cnt;
  int          wait_n;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;

  assign memAck   = memReq && (cnt == wait_n);
  assign memRData = mem[memAddr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (memReq && memAck && !memRnW) mem[memAddr] <= memWData;
    if (memReq && !memAck) cnt <= cnt + 1;
    else cnt <= 0;
  end

  int applied;
  int miscompares;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0][15:0] prog;
    logic [15:0] d10, d11, d20, d21;
    int          waits;
    logic [15:0] e_acc;
    logic [11:0] e_pc;
    logic        e_err;
    logic [11:0] c_addr;
    logic [15:0] c_val;
    int          e_cyc;
  } vec_t;

  function automatic vec_t mk(
    input logic [15:0] w0, w1, w2, w3, w4,
    input logic [15:0] d10, d11, d20, d21,
    input int wt, input logic [15:0] ea, input logic [11:0] ep,
    input logic ee, input logic [11:0] ca, input logic [15:0] cv,
    input int ec);
    vec_t v;
    v.prog = {w4, w3, w2, w1, w0};
    v.d10 = d10; v.d11 = d11; v.d20 = d20; v.d21 = d21;
    v.waits = wt; v.e_acc = ea; v.e_pc = ep; v.e_err = ee;
    v.c_addr = ca; v.c_val = cv; v.e_cyc = ec;
    return v;
  endfunction

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 5; i++) poke(12'(i), v.prog[i]);
    poke(12'd10, v.d10);
    poke(12'd11, v.d11);
    poke(12'd12, 16'h0000);
    poke(12'd20, v.d20);
    poke(12'd21, v.d21);
    wait_n = v.waits;
  endtask

  // Start edge, then count cycles to done, checking that a waiting
  // request holds address and direction.
  task automatic run(input int maxc, output int cyc);
    logic        pend;
    logic [11:0] pa;
    logic        pr;
    pend = 1'b0; pa = '0; pr = 1'b0; cyc = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (!done && cyc < maxc) begin
      if (pend && memReq) begin
        check("hold_addr", 32'(memAddr), 32'(pa));
        check("hold_rnw", 32'(memRnW), 32'(pr));
      end
      pend = memReq && !memAck;
      pa = memAddr;
      pr = memRnW;
      @(negedge clk);
      cyc++;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  vec_t vt [9];
  int   cyc;
  int   n;

  initial begin
    applied = 0; miscompares = 0;
    reset = 1'b0; start = 1'b0; wait_n = 0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
`ifdef MU0_OVERRIDE_EN
    overrideEn = 1'b0; overrideRnW = 1'b1;
    overrideAddr = '0; overrideWData = '0;
`endif

    vt[0] = mk(16'h000A, 16'h200B, 16'h100C, 16'h7000, 16'h0000,
               16'h0005, 16'h0007, 16'h0, 16'h0,
               0, 16'h000C, 12'd4, 1'b0, 12'd12, 16'h000C, 8);
    vt[1] = mk(16'h000A, 16'h200B, 16'h100C, 16'h7000, 16'h0000,
               16'h0005, 16'h0007, 16'h0, 16'h0,
               3, 16'h000C, 12'd4, 1'b0, 12'd12, 16'h000C, 29);
    vt[2] = mk(16'h0014, 16'h3015, 16'h1014, 16'h6000, 16'h7000,
               16'h0, 16'h0, 16'h0003, 16'h0001,
               0, 16'h0000, 12'd5, 1'b0, 12'd20, 16'h0000, 26);
    vt[3] = mk(16'h8000, 16'h0, 16'h0, 16'h0, 16'h0,
               16'h0, 16'h0, 16'h0, 16'h0,
               0, 16'h0000, 12'd1, 1'b1, 12'd0, 16'h8000, 2);
    vt[4] = mk(16'h000A, 16'h5004, 16'h7000, 16'h0000, 16'h7000,
               16'h8000, 16'h0, 16'h0, 16'h0,
               0, 16'h8000, 12'd3, 1'b0, 12'd10, 16'h8000, 6);
    vt[5] = mk(16'h4004, 16'h0, 16'h0, 16'h0, 16'hF000,
               16'h0, 16'h0, 16'h0, 16'h0,
               0, 16'h0000, 12'd5, 1'b1, 12'd4, 16'hF000, 4);
    vt[6] = mk(16'h000A, 16'h200B, 16'h7000, 16'h0, 16'h0,
               16'hFFFF, 16'h0002, 16'h0, 16'h0,
               0, 16'h0001, 12'd3, 1'b0, 12'd10, 16'hFFFF, 6);
    vt[7] = mk(16'h000A, 16'h5004, 16'h7000, 16'h7000, 16'h9000,
               16'h0005, 16'h0, 16'h0, 16'h0,
               0, 16'h0005, 12'd5, 1'b1, 12'd11, 16'h0000, 6);
    vt[8] = mk(16'h0014, 16'h3015, 16'h1014, 16'h6000, 16'h7000,
               16'h0, 16'h0, 16'h0003, 16'h0001,
               1, 16'h0000, 12'd5, 1'b0, 12'd20, 16'h0000, 48);

    #12;
    check("rst_req", 32'(memReq), 32'd0);
    check("rst_rnw", 32'(memRnW), 32'd1);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_acc", 32'(acc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      load(vt[i]);
      run(200, cyc);
      check($sformatf("v%0d_acc", i), 32'(acc), 32'(vt[i].e_acc));
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vt[i].e_pc));
      check($sformatf("v%0d_done", i), 32'(done), 32'd1);
      check($sformatf("v%0d_err", i), 32'(error), 32'(vt[i].e_err));
      check($sformatf("v%0d_mem", i), 32'(mem[vt[i].c_addr]),
            32'(vt[i].c_val));
      check($sformatf("v%0d_cyc", i), 32'(cyc), 32'(vt[i].e_cyc));
      @(negedge clk);
      check($sformatf("v%0d_halt_req", i), 32'(memReq), 32'd0);
      check($sformatf("v%0d_halt_done", i), 32'(done), 32'd1);
    end

    // pc wraps from all-ones to zero after fetching the last word
    wait_n = 0;
    poke(12'd0, 16'h4FFF);
    poke(12'hFFF, 16'h8000);
    run(50, cyc);
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_err", 32'(error), 32'd1);
    check("wrap_cyc", 32'(cyc), 32'd4);

    // restart from a trap clears done/error and refetches at 0
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("rs_done", 32'(done), 32'd0);
    check("rs_err", 32'(error), 32'd0);
    check("rs_req", 32'(memReq), 32'd1);
    check("rs_addr", 32'(memAddr), 32'd0);
    check("rs_rnw", 32'(memRnW), 32'd1);
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rs_halt", 32'(done), 32'd1);

    // reset during a waiting EXEC read aborts immediately
    poke(12'd0, 16'h000A);
    poke(12'd10, 16'h1234);
    wait_n = 4;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(memReq && memAddr == 12'd10) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mr_reach", 32'(memAddr), 32'd10);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mr_req", 32'(memReq), 32'd0);
    check("mr_rnw", 32'(memRnW), 32'd1);
    check("mr_pc", 32'(pc), 32'd0);
    check("mr_ir", 32'(ir), 32'd0);
    check("mr_acc", 32'(acc), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("mr_idle", 32'(memReq), 32'd0);

`ifdef MU0_OVERRIDE_EN
    load(vt[1]);
    poke(12'd5, 16'h0000);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(memReq && cnt == 1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = int'(pc);
    overrideEn = 1'b1; overrideRnW = 1'b0;
    overrideAddr = 12'd5; overrideWData = 16'hBEEF;
    for (int k = 0; k < 20 && !memAck; k++) @(negedge clk);
    @(negedge clk);
    check("ov_frozen_pc", 32'(pc), 32'(n));
    overrideRnW = 1'b1;
    for (int k = 0; k < 20 && !memAck; k++) @(negedge clk);
    check("ov_rdata", 32'(overrideRData), 32'hBEEF);
    @(negedge clk) overrideEn = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ov_done", 32'(done), 32'd1);
    check("ov_acc", 32'(acc), 32'h000C);
    check("ov_err", 32'(error), 32'd0);
    check("ov_mem12", 32'(mem[12]), 32'h000C);
    check("ov_mem5", 32'(mem[5]), 32'hBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
